// File: rtl/rv_test_pkg.sv
// Shared definitions for the riscv-tests verdict reporter: message bytes,
// FSM encoding and the default halt PC (also used by simulation benches).
package rv_test_pkg;

    localparam logic [31:0] HALT_PC_DEFAULT = 32'h0000_0044;

    localparam int unsigned MSG_LEN = 7;

    // Index 0 is the first byte on the wire.
    localparam logic [0:MSG_LEN-1][7:0] MSG_PASS =
        {8'h70, 8'h61, 8'h73, 8'h73, 8'h65, 8'h64, 8'h0A};
    localparam logic [0:MSG_LEN-1][7:0] MSG_FAIL =
        {8'h66, 8'h61, 8'h69, 8'h6C, 8'h65, 8'h64, 8'h0A};

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSend = 2'd1,
        StDone = 2'd2
    } state_e;

    // Byte idx of the verdict line; idx is kept within 0..MSG_LEN-1 by the caller.
    function automatic logic [7:0] msg_byte(input logic verdict, input logic [2:0] idx);
        return verdict ? MSG_PASS[idx] : MSG_FAIL[idx];
    endfunction

endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter. Accepts a byte when byte_valid && byte_ready.
// byte_ready is also high on the last cycle of a stop bit, so a byte offered
// then starts its start bit immediately with no idle gap.
module uart_tx_8n1 #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       tx
);

    localparam int unsigned TimerW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TimerW-1:0] TimerMax = TimerW'(CLKS_PER_BIT - 1);

    logic              active_q, active_d;
    logic              tx_q, tx_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [3:0]        bit_q, bit_d;     // 0 start, 1..8 data, 9 stop
    logic [7:0]        data_q, data_d;

    logic bit_end;
    logic last_cycle;

    assign bit_end    = (timer_q == TimerMax);
    assign last_cycle = active_q && bit_end && (bit_q == 4'd9);
    assign byte_ready = !active_q || last_cycle;
    assign tx         = tx_q;

    // Next-state: load a new frame, or advance bit timer / bit index.
    always_comb begin
        active_d = active_q;
        tx_d     = tx_q;
        timer_d  = timer_q;
        bit_d    = bit_q;
        data_d   = data_q;
        if (byte_valid && byte_ready) begin
            active_d = 1'b1;
            tx_d     = 1'b0;
            timer_d  = '0;
            bit_d    = 4'd0;
            data_d   = byte_data;
        end else if (active_q) begin
            if (bit_end) begin
                timer_d = '0;
                if (bit_q == 4'd9) begin
                    active_d = 1'b0;
                    tx_d     = 1'b1;
                    bit_d    = 4'd0;
                end else begin
                    bit_d = bit_q + 4'd1;
                    // Entering bit_q+1: data bit bit_q, or the stop bit after d7.
                    tx_d  = (bit_q == 4'd8) ? 1'b1 : data_q[bit_q[2:0]];
                end
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    // State register with synchronous reset to an idle-high line.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            tx_q     <= 1'b1;
            timer_q  <= '0;
            bit_q    <= 4'd0;
            data_q   <= 8'h00;
        end else begin
            active_q <= active_d;
            tx_q     <= tx_d;
            timer_q  <= timer_d;
            bit_q    <= bit_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: rtl/rv_test_result_tx.sv
// Watches the retiring PC and gp (x3); on the halt PC, or after a timeout,
// sends "passed\n" or "failed\n" over an 8N1 UART and raises sticky flags.
module rv_test_result_tx
    import rv_test_pkg::*;
#(
    parameter logic [31:0] HALT_PC      = HALT_PC_DEFAULT,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned TIMEOUT      = 5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_valid,
    input  logic [31:0] pc,
    input  logic [31:0] gp,
    output logic        uart_tx,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timed_out
);

    state_e      state_q, state_d;
    logic        pass_q, pass_d;
    logic        timed_out_q, timed_out_d;
    logic        done_q, done_d;
    logic [2:0]  idx_q, idx_d;          // byte currently in flight, 0..MSG_LEN-1
    logic [31:0] tmo_cnt_q, tmo_cnt_d;

    logic       halt_hit;
    logic       timeout_hit;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;

    assign halt_hit    = pc_valid && (pc == HALT_PC);
    assign timeout_hit = (TIMEOUT != 0) && (tmo_cnt_q == 32'(TIMEOUT - 1));

    // Next-state and byte hand-off; the first byte is offered on the trigger
    // edge itself so the start bit appears on the following cycle.
    always_comb begin
        state_d     = state_q;
        pass_d      = pass_q;
        timed_out_d = timed_out_q;
        done_d      = done_q;
        idx_d       = idx_q;
        tmo_cnt_d   = tmo_cnt_q;
        byte_valid  = 1'b0;
        byte_data   = 8'h00;
        unique case (state_q)
            StIdle: begin
                tmo_cnt_d = tmo_cnt_q + 32'd1;
                if (halt_hit) begin
                    pass_d     = (gp == 32'h1);
                    state_d    = StSend;
                    idx_d      = 3'd0;
                    byte_valid = 1'b1;
                    byte_data  = msg_byte(gp == 32'h1, 3'd0);
                end else if (timeout_hit) begin
                    pass_d      = 1'b0;
                    timed_out_d = 1'b1;
                    state_d     = StSend;
                    idx_d       = 3'd0;
                    byte_valid  = 1'b1;
                    byte_data   = msg_byte(1'b0, 3'd0);
                end
            end
            StSend: begin
                if (byte_ready) begin
                    if (idx_q == 3'(MSG_LEN - 1)) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        idx_d      = idx_q + 3'd1;
                        byte_valid = 1'b1;
                        byte_data  = msg_byte(pass_q, idx_q + 3'd1);
                    end
                end
            end
            StDone: begin
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM and sticky flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            pass_q      <= 1'b0;
            timed_out_q <= 1'b0;
            done_q      <= 1'b0;
            idx_q       <= 3'd0;
            tmo_cnt_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            pass_q      <= pass_d;
            timed_out_q <= timed_out_d;
            done_q      <= done_d;
            idx_q       <= idx_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    uart_tx_8n1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk       (clk),
        .rst       (rst),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_ready(byte_ready),
        .tx        (uart_tx)
    );

    assign busy      = (state_q == StSend);
    assign done      = done_q;
    assign pass      = pass_q;
    assign timed_out = timed_out_q;

endmodule

// File: tb/tb_rv_test_result_tx.sv
// Directed bench for rv_test_result_tx with CLKS_PER_BIT=4, TIMEOUT=200.
module tb_rv_test_result_tx;

    localparam int CPB = 4;
    localparam int TMO = 200;
    localparam logic [31:0] HALT = 32'h44;
    // Byte 0 in bits [7:0].
    localparam logic [55:0] LINE_PASS = 56'h0A_64_65_73_73_61_70;
    localparam logic [55:0] LINE_FAIL = 56'h0A_64_65_6C_69_61_66;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_valid = 1'b0;
    logic [31:0] pc = 32'h0;
    logic [31:0] gp = 32'h0;
    logic        uart_tx, busy, done, pass, timed_out;

    int total = 0;
    int bad = 0;

    rv_test_result_tx #(
        .HALT_PC     (HALT),
        .CLKS_PER_BIT(CPB),
        .TIMEOUT     (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pc_valid (pc_valid),
        .pc       (pc),
        .gp       (gp),
        .uart_tx  (uart_tx),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .timed_out(timed_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // After return, the next posedge is cycle 0 after reset release.
    task automatic do_reset();
        rst = 1'b1; pc_valid = 1'b0; pc = 32'h0; gp = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Called 1 time unit after the trigger edge; samples every cycle of all 70 bits.
    task automatic rx_line(output logic [55:0] line, output int unstable, output int framing,
                           output int early);
        logic s0;
        line = '0; unstable = 0; framing = 0; early = 0;
        for (int j = 0; j < 7; j++) begin
            for (int k = 0; k < 10; k++) begin
                s0 = uart_tx;
                if (done !== 1'b0) early++;
                for (int c = 1; c < CPB; c++) begin
                    @(posedge clk); #1;
                    if (uart_tx !== s0) unstable++;
                    if (done !== 1'b0) early++;
                end
                @(posedge clk); #1;
                if (k == 0 && s0 !== 1'b0) framing++;
                if (k == 9 && s0 !== 1'b1) framing++;
                if (k >= 1 && k <= 8) line[8*j + k - 1] = s0;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL rst_tx: got %b want 1", uart_tx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
        total++; if (pass !== 1'b0) begin bad++; $display("FAIL rst_pass: got %b want 0", pass); end
        total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL rst_tmo: got %b want 0", timed_out); end
    endtask

    task automatic test_pass();
        logic [55:0] line; int u, f, e;
        do_reset();
        pc_valid = 1'b1; pc = 32'h0; gp = 32'h1;
        wait_edges(20);
        total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL t1_idle: got %b want 1", uart_tx); end
        pc = HALT;
        wait_edges(1);
        total++; if (uart_tx !== 1'b0) begin bad++; $display("FAIL t1_start: got %b want 0", uart_tx); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL t1_busy: got %b want 1", busy); end
        rx_line(line, u, f, e);
        total++; if (line !== LINE_PASS) begin bad++; $display("FAIL t1_line: got %h want %h", line, LINE_PASS); end
        total++; if (e !== 0) begin bad++; $display("FAIL t1_early_done: got %0d want 0", e); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL t1_done: got %b want 1", done); end
        total++; if (pass !== 1'b1) begin bad++; $display("FAIL t1_pass: got %b want 1", pass); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t1_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_fail();
        logic [55:0] line; int u, f, e;
        do_reset();
        pc_valid = 1'b1; pc = 32'h0; gp = 32'h5;
        wait_edges(20);
        pc = HALT;
        wait_edges(1);
        total++; if (uart_tx !== 1'b0) begin bad++; $display("FAIL t2_start: got %b want 0", uart_tx); end
        rx_line(line, u, f, e);
        total++; if (line !== LINE_FAIL) begin bad++; $display("FAIL t2_line: got %h want %h", line, LINE_FAIL); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL t2_done: got %b want 1", done); end
        total++; if (pass !== 1'b0) begin bad++; $display("FAIL t2_pass: got %b want 0", pass); end
        total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL t2_tmo: got %b want 0", timed_out); end
    endtask

    task automatic test_timeout();
        logic [55:0] line; int u, f, e;
        do_reset();
        pc_valid = 1'b0; pc = HALT; gp = 32'h1;
        wait_edges(199);
        total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL t3_pre: got %b want 1", uart_tx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t3_pre_busy: got %b want 0", busy); end
        wait_edges(1);
        total++; if (uart_tx !== 1'b0) begin bad++; $display("FAIL t3_start: got %b want 0", uart_tx); end
        total++; if (timed_out !== 1'b1) begin bad++; $display("FAIL t3_tmo: got %b want 1", timed_out); end
        rx_line(line, u, f, e);
        total++; if (line !== LINE_FAIL) begin bad++; $display("FAIL t3_line: got %h want %h", line, LINE_FAIL); end
        total++; if (pass !== 1'b0) begin bad++; $display("FAIL t3_pass: got %b want 0", pass); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL t3_done: got %b want 1", done); end
    endtask

    task automatic test_ignore_during_send();
        logic [55:0] line; int u, f, e; int errs;
        do_reset();
        pc_valid = 1'b1; pc = 32'h0; gp = 32'h1;
        wait_edges(20);
        pc = HALT;
        wait_edges(1);
        fork
            rx_line(line, u, f, e);
            begin
                for (int i = 0; i < 60; i++) begin
                    wait_edges(3);
                    gp = i[0] ? 32'h1 : 32'hDEAD;
                    pc_valid = ~i[0];
                    pc = HALT;
                end
            end
        join
        total++; if (line !== LINE_PASS) begin bad++; $display("FAIL t4_line: got %h want %h", line, LINE_PASS); end
        total++; if (pass !== 1'b1) begin bad++; $display("FAIL t4_pass: got %b want 1", pass); end
        pc_valid = 1'b1; pc = HALT; gp = 32'h5;
        errs = 0;
        for (int i = 0; i < 50; i++) begin
            wait_edges(1);
            if (uart_tx !== 1'b1 || busy !== 1'b0 || done !== 1'b1 || pass !== 1'b1) errs++;
        end
        total++; if (errs !== 0) begin bad++; $display("FAIL t4_after_done: got %0d bad cycles want 0", errs); end
    endtask

    task automatic test_reset_mid();
        logic [55:0] line; int u, f, e;
        do_reset();
        pc_valid = 1'b1; pc = 32'h0; gp = 32'h1;
        wait_edges(20);
        pc = HALT;
        wait_edges(1);
        // Cycle T+139: byte 3 (0x73), data bit d3 = 0.
        wait_edges(139);
        total++; if (uart_tx !== 1'b0) begin bad++; $display("FAIL t5_mid_low: got %b want 0", uart_tx); end
        rst = 1'b1;
        wait_edges(1);
        total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL t5_rst_tx: got %b want 1", uart_tx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t5_rst_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL t5_rst_done: got %b want 0", done); end
        total++; if (pass !== 1'b0) begin bad++; $display("FAIL t5_rst_pass: got %b want 0", pass); end
        rst = 1'b0; pc_valid = 1'b1; pc = 32'h0; gp = 32'h1;
        wait_edges(5);
        pc = HALT;
        wait_edges(1);
        total++; if (uart_tx !== 1'b0) begin bad++; $display("FAIL t5_restart: got %b want 0", uart_tx); end
        rx_line(line, u, f, e);
        total++; if (line !== LINE_PASS) begin bad++; $display("FAIL t5_line: got %h want %h", line, LINE_PASS); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL t5_done: got %b want 1", done); end
    endtask

    task automatic test_halt_on_timeout();
        logic [55:0] line; int u, f, e;
        do_reset();
        pc_valid = 1'b0; pc = 32'h0; gp = 32'h1;
        wait_edges(199);
        pc_valid = 1'b1; pc = HALT;
        wait_edges(1);
        total++; if (uart_tx !== 1'b0) begin bad++; $display("FAIL t6_start: got %b want 0", uart_tx); end
        total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL t6_tmo0: got %b want 0", timed_out); end
        rx_line(line, u, f, e);
        total++; if (line !== LINE_PASS) begin bad++; $display("FAIL t6_line: got %h want %h", line, LINE_PASS); end
        total++; if (u !== 0) begin bad++; $display("FAIL t6_bit_hold: got %0d changes want 0", u); end
        total++; if (f !== 0) begin bad++; $display("FAIL t6_framing: got %0d errors want 0", f); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL t6_done: got %b want 1", done); end
        total++; if (pass !== 1'b1) begin bad++; $display("FAIL t6_pass: got %b want 1", pass); end
        total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL t6_tmo: got %b want 0", timed_out); end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_timeout();
        test_ignore_during_send();
        test_reset_mid();
        test_halt_on_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
